// File: rtl/ahb_ext_waitmem_if.sv
// AHB-Lite bus bundle for the external wait-state memory model.
// The manager side drives address/data/control and the bus-level HREADY.
interface ahb_ext_waitmem_if #(
    parameter int AHBW    = 64,
    parameter int PA_BITS = 56
);
    logic                HSEL;
    logic [PA_BITS-1:0]  HADDR;
    logic [AHBW-1:0]     HWDATA;
    logic [AHBW/8-1:0]   HWSTRB;
    logic                HWRITE;
    logic [2:0]          HSIZE;
    logic [1:0]          HTRANS;
    logic                HREADY;
    logic [AHBW-1:0]     HRDATA;
    logic                HREADYOUT;
    logic                HRESP;

    modport slave (
        input  HSEL, HADDR, HWDATA, HWSTRB, HWRITE,
        input  HSIZE, HTRANS, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

    modport master (
        output HSEL, HADDR, HWDATA, HWSTRB, HWRITE,
        output HSIZE, HTRANS, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_ext_waitmem.sv
// AHB-Lite off-chip memory model behind HSELEXT: byte-writable word
// array, programmable wait states and the two-cycle ERROR response.
module ahb_ext_waitmem #(
    parameter int                 AHBW        = 64,
    parameter int                 PA_BITS     = 56,
    parameter int                 DEPTH       = 1024,
    parameter logic [PA_BITS-1:0] BASE        = PA_BITS'(64'h8000_0000),
    parameter int                 WAIT_STATES = 2
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_ext_waitmem_if.slave  bus
);

    localparam int BW  = AHBW / 8;
    localparam int OFF = $clog2(BW);
    localparam int IW  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              write_q, write_d;
    logic [AHBW-1:0]   rdata_q, rdata_d;
    logic [AHBW-1:0]   mem_q [DEPTH];

    logic [PA_BITS-1:0] offs;
    logic [PA_BITS-1:0] word;
    logic [PA_BITS-1:0] amask;
    logic               below;
    logic               oor;
    logic               misal;
    logic               oversz;
    logic               bad;
    logic               done;
    logic               accept;
    logic               acc_ok;
    logic               acc_bad;
    logic               rd_fire;
    logic               wr_fire;
    logic               ready;
    logic               resp;
    logic               unused_htrans;

    assign unused_htrans = bus.HTRANS[0];

    always_comb begin
        offs   = bus.HADDR - BASE;
        word   = offs >> OFF;
        amask  = (PA_BITS'(1) << bus.HSIZE) - PA_BITS'(1);
        below  = bus.HADDR < BASE;
        oor    = below || (word >= PA_BITS'(DEPTH));
        misal  = (bus.HADDR & amask) != '0;
        oversz = bus.HSIZE > 3'(OFF);
        bad    = oor || misal || oversz;
    end

    // A new address phase is only taken while idle or as the data
    // phase completes; ERR2 drops the cancelled address phase.
    assign done    = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign accept  = bus.HSEL && bus.HREADY && bus.HTRANS[1]
                     && ((state_q == S_IDLE) || done);
    assign acc_ok  = accept && !bad;
    assign acc_bad = accept && bad;
    assign rd_fire = done && !write_q;
    assign wr_fire = done && write_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        rdata_d = rdata_q;
        ready   = 1'b1;
        resp    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
            end
            S_WAIT: begin
                ready = done;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!write_q) begin
                        rdata_d = mem_q[idx_q];
                    end
                    state_d = S_IDLE;
                end
            end
            S_ERR1: begin
                ready   = 1'b0;
                resp    = 1'b1;
                state_d = S_ERR2;
            end
            S_ERR2: begin
                resp    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (acc_ok) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
            idx_d   = word[IW-1:0];
            write_d = bus.HWRITE;
        end else if (acc_bad) begin
            state_d = S_ERR1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is deliberately not reset; reset forces IDLE so no write fires.
    always_ff @(posedge HCLK) begin
        if (wr_fire) begin
            for (int i = 0; i < BW; i++) begin
                if (bus.HWSTRB[i]) begin
                    mem_q[idx_q][i*8 +: 8] <= bus.HWDATA[i*8 +: 8];
                end
            end
        end
    end

    assign bus.HRDATA    = rd_fire ? mem_q[idx_q] : rdata_q;
    assign bus.HREADYOUT = ready;
    assign bus.HRESP     = resp;

endmodule

// File: tb/tb_ahb_ext_waitmem.sv
// Bench for ahb_ext_waitmem: two instances (2 and 0 wait states),
// vector table driven through a pipelined manager with a scoreboard.
module tb_ahb_ext_waitmem;

    localparam logic [55:0] BASE = 56'h8000_0000;

    typedef struct {
        bit          wr;
        logic [55:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [7:0]  strb;
        bit          err;
        logic [63:0] rdata;
    } vec_t;

    typedef struct {
        bit          wr;
        bit          err;
        logic [63:0] rdata;
        int          id;
    } exp_t;

    logic        clk;
    logic        rst2_n;
    logic        rst0_n;
    logic        use0;
    logic        hsel;
    logic [1:0]  htrans;
    logic [55:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [63:0] hwdata;
    logic [7:0]  hwstrb;
    logic        rdy;
    logic        resp;
    logic [63:0] hrdata;

    int          errors;
    int          checks;
    vec_t        vt [23];
    exp_t        sb [$];
    logic [63:0] last_rd [2];

    ahb_ext_waitmem_if #(.AHBW(64), .PA_BITS(56)) bus2 ();
    ahb_ext_waitmem_if #(.AHBW(64), .PA_BITS(56)) bus0 ();

    assign bus2.HSEL   = hsel & ~use0;
    assign bus0.HSEL   = hsel & use0;
    assign bus2.HADDR  = haddr;
    assign bus0.HADDR  = haddr;
    assign bus2.HWDATA = hwdata;
    assign bus0.HWDATA = hwdata;
    assign bus2.HWSTRB = hwstrb;
    assign bus0.HWSTRB = hwstrb;
    assign bus2.HWRITE = hwrite;
    assign bus0.HWRITE = hwrite;
    assign bus2.HSIZE  = hsize;
    assign bus0.HSIZE  = hsize;
    assign bus2.HTRANS = htrans;
    assign bus0.HTRANS = htrans;
    assign bus2.HREADY = bus2.HREADYOUT;
    assign bus0.HREADY = bus0.HREADYOUT;

    assign rdy    = use0 ? bus0.HREADYOUT : bus2.HREADYOUT;
    assign resp   = use0 ? bus0.HRESP : bus2.HRESP;
    assign hrdata = use0 ? bus0.HRDATA : bus2.HRDATA;

    ahb_ext_waitmem #(
        .AHBW(64), .PA_BITS(56), .DEPTH(1024),
        .BASE(BASE), .WAIT_STATES(2)
    ) u_ws2 (
        .HCLK(clk), .HRESETn(rst2_n), .bus(bus2)
    );

    ahb_ext_waitmem #(
        .AHBW(64), .PA_BITS(56), .DEPTH(1024),
        .BASE(BASE), .WAIT_STATES(0)
    ) u_ws0 (
        .HCLK(clk), .HRESETn(rst0_n), .bus(bus0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pipelined manager: enter and leave 1 time unit after a rising edge.
    task automatic run_vec(input int lo, input int hi, input bit d0,
                           input int ws);
        int   k;
        int   guard;
        int   dp;
        int   nw;
        bit   dpv;
        bit   errs;
        bit   idle1;
        bit   rdfire;
        exp_t e;
        k = lo; guard = 0; dp = 0; nw = 0;
        dpv = 0; errs = 0; idle1 = 0;
        use0 = d0;
        while ((k <= hi || dpv) && guard < 300) begin
            guard++;
            if (k <= hi && !idle1) begin
                hsel   = 1'b1;
                htrans = 2'b10;
                haddr  = vt[k].addr;
                hwrite = vt[k].wr;
                hsize  = vt[k].size;
            end else begin
                hsel   = 1'b0;
                htrans = 2'b00;
            end
            idle1 = 1'b0;
            if (dpv) begin
                hwdata = vt[dp].wdata;
                hwstrb = vt[dp].strb;
            end
            @(negedge clk);
            rdfire = 1'b0;
            if (dpv && !rdy) begin
                nw++;
                if (resp) begin
                    errs   = 1'b1;
                    idle1  = 1'b1;
                    hsel   = 1'b0;
                    htrans = 2'b00;
                end
            end else if (dpv) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: got empty queue expected entry %0d", dp);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("hresp[%0d]", e.id), 64'(resp), 64'(e.err));
                    chk($sformatf("err1[%0d]", e.id), 64'(errs), 64'(e.err));
                    chk($sformatf("waits[%0d]", e.id), 64'(nw),
                        e.err ? 64'd1 : 64'(ws));
                    if (!e.wr && !e.err) begin
                        rdfire = 1'b1;
                        chk($sformatf("rdata[%0d]", e.id), hrdata, e.rdata);
                        last_rd[d0] = e.rdata;
                    end
                end
                dpv = 1'b0;
            end
            if (!rdfire) begin
                chk("hrdata_hold", hrdata, last_rd[d0]);
            end
            if (rdy && htrans[1] && k <= hi) begin
                sb.push_back('{vt[k].wr, vt[k].err, vt[k].rdata, k});
                dp = k; dpv = 1'b1; nw = 0; errs = 1'b0;
                k++;
            end
            @(posedge clk);
            #1;
        end
        hsel   = 1'b0;
        htrans = 2'b00;
        if (guard >= 300) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no completion for vectors %0d..%0d", lo, hi);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation stuck expected finish");
        $fatal(1);
    end

    initial begin
        clk = 1'b0; rst2_n = 1'b0; rst0_n = 1'b0; use0 = 1'b0;
        hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
        hsize = 3'd0; hwdata = '0; hwstrb = '0;
        errors = 0; checks = 0;
        last_rd[0] = '0; last_rd[1] = '0;

        vt[0]  = '{1'b1, BASE, 3'd3, 64'h1122334455667788, 8'hFF, 1'b0, 64'h0};
        vt[1]  = '{1'b0, BASE, 3'd3, 64'h0, 8'h00, 1'b0, 64'h1122334455667788};
        vt[2]  = '{1'b1, BASE, 3'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 64'h0};
        vt[3]  = '{1'b0, BASE, 3'd3, 64'h0, 8'h00, 1'b0, 64'h11223344AAAAAAAA};
        vt[4]  = '{1'b0, BASE + 56'h2000, 3'd3, 64'h0, 8'h00, 1'b1, 64'h0};
        vt[5]  = '{1'b1, BASE + 56'h4, 3'd3, 64'hDEADBEEFDEADBEEF, 8'hFF, 1'b1, 64'h0};
        vt[6]  = '{1'b0, BASE, 3'd3, 64'h0, 8'h00, 1'b0, 64'h11223344AAAAAAAA};
        vt[7]  = '{1'b0, BASE - 56'h8, 3'd3, 64'h0, 8'h00, 1'b1, 64'h0};
        vt[8]  = '{1'b1, BASE + 56'h1FF8, 3'd3, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 64'h0};
        vt[9]  = '{1'b0, BASE + 56'h1FF8, 3'd3, 64'h0, 8'h00, 1'b0, 64'h0123456789ABCDEF};
        vt[10] = '{1'b0, BASE, 3'd4, 64'h0, 8'h00, 1'b1, 64'h0};
        vt[11] = '{1'b0, BASE + 56'h4, 3'd2, 64'h0, 8'h00, 1'b0, 64'h11223344AAAAAAAA};
        vt[12] = '{1'b1, BASE, 3'd3, 64'h1000, 8'hFF, 1'b0, 64'h0};
        vt[13] = '{1'b1, BASE + 56'h8, 3'd3, 64'h2000, 8'hFF, 1'b0, 64'h0};
        vt[14] = '{1'b1, BASE + 56'h10, 3'd3, 64'h3000, 8'hFF, 1'b0, 64'h0};
        vt[15] = '{1'b1, BASE + 56'h18, 3'd3, 64'h4000, 8'hFF, 1'b0, 64'h0};
        vt[16] = '{1'b0, BASE, 3'd3, 64'h0, 8'h00, 1'b0, 64'h1000};
        vt[17] = '{1'b0, BASE + 56'h8, 3'd3, 64'h0, 8'h00, 1'b0, 64'h2000};
        vt[18] = '{1'b0, BASE + 56'h10, 3'd3, 64'h0, 8'h00, 1'b0, 64'h3000};
        vt[19] = '{1'b0, BASE + 56'h18, 3'd3, 64'h0, 8'h00, 1'b0, 64'h4000};
        vt[20] = '{1'b1, BASE + 56'h8, 3'd3, 64'hCAFEF00D00002222, 8'hFF, 1'b0, 64'h0};
        vt[21] = '{1'b0, BASE + 56'h8, 3'd3, 64'h0, 8'h00, 1'b0, 64'hCAFEF00D00002222};
        vt[22] = '{1'b0, BASE + 56'h2000, 3'd3, 64'h0, 8'h00, 1'b1, 64'h0};

        #3;
        chk("rst_ready_ws2", 64'(bus2.HREADYOUT), 64'd1);
        chk("rst_resp_ws2", 64'(bus2.HRESP), 64'd0);
        chk("rst_rdata_ws2", bus2.HRDATA, 64'd0);
        chk("rst_ready_ws0", 64'(bus0.HREADYOUT), 64'd1);
        chk("rst_resp_ws0", 64'(bus0.HRESP), 64'd0);
        chk("rst_rdata_ws0", bus0.HRDATA, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        rst0_n = 1'b1;
        @(posedge clk);
        #1;

        run_vec(0, 11, 1'b0, 2);
        run_vec(12, 22, 1'b1, 0);

        // Reset lands in the second wait cycle of a write.
        use0 = 1'b0;
        hsel = 1'b1; htrans = 2'b10; haddr = BASE;
        hwrite = 1'b1; hsize = 3'd3;
        @(posedge clk);
        #1;
        hsel = 1'b0; htrans = 2'b00;
        hwdata = 64'h5555555555555555; hwstrb = 8'hFF;
        @(negedge clk);
        chk("rstw_wait1", 64'(rdy), 64'd0);
        @(posedge clk);
        #2;
        rst2_n = 1'b0;
        #1;
        chk("rstw_ready", 64'(rdy), 64'd1);
        chk("rstw_resp", 64'(resp), 64'd0);
        chk("rstw_rdata", hrdata, 64'd0);
        last_rd[0] = '0;
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(3, 3, 1'b0, 2);

        // IDLE then BUSY transfers with HSEL high are ignored.
        for (int i = 0; i < 4; i++) begin
            hsel = 1'b1;
            htrans = (i < 2) ? 2'b00 : 2'b01;
            haddr = BASE; hwrite = 1'b1; hsize = 3'd3;
            hwdata = 64'hFFFFFFFFFFFFFFFF; hwstrb = 8'hFF;
            @(negedge clk);
            chk($sformatf("idle_ready[%0d]", i), 64'(rdy), 64'd1);
            chk($sformatf("idle_resp[%0d]", i), 64'(resp), 64'd0);
            chk($sformatf("idle_hold[%0d]", i), hrdata, last_rd[0]);
            @(posedge clk);
            #1;
        end
        hsel = 1'b0; htrans = 2'b00;
        run_vec(3, 3, 1'b0, 2);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_left: got %0d entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_ext_waitmem.md
Name: ahb_ext_waitmem

Overview:
- AHB-Lite subordinate that models the off-chip memory behind the HSELEXT region of the uncore.
- Feeds HRDATAEXT, HREADYEXT and HRESPEXT back into the uncore read/ready/response multiplexer.
- Provides a byte-writable word array with a configurable number of wait states per transfer.
- Generates the two-cycle AHB ERROR response for out-of-range or misaligned accesses, exercising the uncore's HSEL-delay and HREADY-stall paths.

Parameters:
- AHBW, 64: data bus width in bits; must be 32 or 64.
- PA_BITS, 56: address width.
- DEPTH, 1024: number of AHBW-wide words.
- BASE, 0x8000_0000: byte address of word 0.
- WAIT_STATES, 2: wait cycles per accepted transfer; legal range 0..15.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  region select; connects to HSELEXT.
- HADDR  in  PA_BITS  address-phase address.
- HWDATA  in  AHBW  write data, valid in the data phase.
- HWSTRB  in  AHBW/8  byte strobes, valid in the data phase.
- HWRITE  in  1  address-phase write flag.
- HSIZE  in  3  address-phase transfer size.
- HTRANS  in  2  address-phase transfer type.
- HREADY  in  1  bus-level ready; address phase is sampled only when high.
- HRDATA  out  AHBW  read data; connects to HRDATAEXT.
- HREADYOUT  out  1  ready; connects to HREADYEXT.
- HRESP  out  1  error response; connects to HRESPEXT.

Behaviour:
- Reset (asynchronous, HRESETn=0):
  - State goes to IDLE.
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - Wait counter=0; latched address and control cleared.
  - Array contents are not reset.
- Accept condition: HSEL & HREADY & HTRANS[1] at a rising edge latches HADDR, HWRITE and HSIZE.
  - IDLE and BUSY transfers (HTRANS[1]=0) are never accepted and get a zero-wait OKAY response.
- Error check, evaluated at accept:
  - Word index (HADDR-BASE)>>log2(AHBW/8) is >= DEPTH, or HADDR < BASE, or
  - HADDR is not aligned to 2^HSIZE, or
  - HSIZE > log2(AHBW/8).
- States:
  - IDLE: HREADYOUT=1, HRESP=0. On a good accept, go to WAIT with count=WAIT_STATES. On a bad accept, go to ERR1.
  - WAIT: HREADYOUT=(count==0). While count>0, decrement each cycle. When count==0, the data phase completes this cycle:
    - Write: each byte lane i with HWSTRB[i]=1 is updated with HWDATA lane i at the edge.
    - Read: HRDATA drives the full word at the latched index, combinational from the array.
    - Transition: an accept in the same cycle (pipelined next address) re-enters WAIT or ERR1; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Any address phase in this cycle is ignored (not accepted), since the manager cancels it per AHB-Lite; go to IDLE.
- Latency: WAIT_STATES+1 data-phase cycles per good transfer. With WAIT_STATES=0, back-to-back transfers sustain one per cycle.
- Read-after-write: a write commits at the edge ending its data phase. The following read's data phase reads the array after that edge, so no forwarding is required.
- HRDATA outside a completing read holds its last value. It is don't-care to the bus, but the bench checks it is stable.
- Errored writes never modify the array.
- HSEL deasserting during WAIT has no effect; the latched transfer completes.
- Reset asserted mid-WAIT: the transfer is abandoned and no write occurs.

Test Plan:
1. WAIT_STATES=2: write 0x1122334455667788 to BASE with HWSTRB=0xFF, then read BASE -> HREADYOUT low for 2 cycles in each data phase; read returns 0x1122334455667788.
2. Byte strobe: write 0xAA..AA with HWSTRB=0x0F over the test 1 word, then read -> 0x11223344AAAAAAAA.
3. WAIT_STATES=0: back-to-back pipelined writes to 4 consecutive words, then 4 reads -> HREADYOUT held at 1 throughout; each read returns its word; a read immediately after a write to the same address returns the new data.
4. Out of range: read at BASE+DEPTH*8 -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, then IDLE. Misaligned HSIZE=3 write at BASE+4 -> same two-cycle ERROR, and the array is unchanged.
5. Assert HRESETn=0 during the second wait cycle of a write -> outputs immediately HREADYOUT=1, HRESP=0, HRDATA=0; a subsequent read shows the old data.
6. HTRANS=IDLE with HSEL=1 -> no state change; HREADYOUT=1, HRESP=0 every cycle.
